// File: rtl/tree_packet_dispatch_rr_if.sv
// Packet stream bundle: data beat fields plus a valid/ready handshake.
// The master drives the beat, the slave drives rdy.
interface tree_packet_dispatch_rr_if #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = 3
);
    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;
    logic                rdy;

    modport master (
        output dat, val, sop, eop, err, mod, ctl,
        input  rdy
    );

    modport slave (
        input  dat, val, sop, eop, err, mod, ctl,
        output rdy
    );
endinterface

// File: rtl/tree_packet_dispatch_rr.sv
// Credit-gated round-robin packet dispatcher: stamps a channel id into ctl
// and forwards each beat through one back-pressured register stage.
module tree_packet_dispatch_rr #(
    parameter int DAT_BYTS     = 8,
    parameter int DAT_BITS     = DAT_BYTS * 8,
    parameter int CTL_BITS     = 8,
    parameter int NUM_OUT      = 8,
    parameter int LOG2_NUM_OUT = (NUM_OUT == 1) ? 1 : $clog2(NUM_OUT),
    parameter int OVR_WRT_BIT  = CTL_BITS - LOG2_NUM_OUT,
    parameter int MAX_CRED     = 4,
    parameter int CRED_BITS    = $clog2(MAX_CRED + 1),
    parameter int MOD_BITS     = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    tree_packet_dispatch_rr_if.slave      i_axi,
    tree_packet_dispatch_rr_if.master     o_axi,
    input  logic [NUM_OUT-1:0]            i_cred_ret,
    output logic [NUM_OUT*CRED_BITS-1:0]  o_cred,
    output logic                          o_cred_err
);
    typedef enum logic {IDLE, IN_PKT} state_t;

    localparam logic [CRED_BITS-1:0] CRED_MAX = CRED_BITS'(MAX_CRED);

    state_t                  state;
    logic [LOG2_NUM_OUT-1:0] rr_ptr;
    logic [LOG2_NUM_OUT-1:0] cur_ch;
    logic [LOG2_NUM_OUT-1:0] pick;
    logic [LOG2_NUM_OUT-1:0] idx;
    logic [LOG2_NUM_OUT-1:0] nxt_ptr;
    logic [LOG2_NUM_OUT-1:0] ch;
    logic [CRED_BITS-1:0]    cred [NUM_OUT];
    logic [NUM_OUT-1:0]      cons;
    logic                    found;
    logic                    gate;
    logic                    accept;
    logic                    take;
    logic [CTL_BITS-1:0]     ctl_stamp;
    int                      j;

    // Walk down from the farthest offset so the nearest eligible channel wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_OUT) j = j - NUM_OUT;
            idx = LOG2_NUM_OUT'(j);
            if (cred[idx] != '0) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign nxt_ptr = (int'(pick) == NUM_OUT - 1) ? '0 : pick + 1'b1;
    assign gate    = (state == IN_PKT) | found;
    assign i_axi.rdy = (~o_axi.val | o_axi.rdy) & gate;
    assign accept  = i_axi.val & i_axi.rdy;
    assign take    = accept & (state == IDLE) & i_axi.sop;
    assign ch      = take ? pick : cur_ch;
    assign cons    = take ? (NUM_OUT'(1) << pick) : '0;

    always_comb begin
        ctl_stamp = i_axi.ctl;
        ctl_stamp[OVR_WRT_BIT +: LOG2_NUM_OUT] = ch;
    end

    always_comb begin
        o_cred = '0;
        for (int c = 0; c < NUM_OUT; c++) begin
            o_cred[c*CRED_BITS +: CRED_BITS] = cred[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_ch <= '0;
        end else if (take) begin
            cur_ch <= pick;
            rr_ptr <= nxt_ptr;
            state  <= i_axi.eop ? IDLE : IN_PKT;
        end else if (accept && state == IN_PKT && i_axi.eop) begin
            state <= IDLE;
        end
    end

    // A same-cycle return and consume on one channel cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_OUT; c++) cred[c] <= CRED_MAX;
            o_cred_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_OUT; c++) begin
                if (i_cred_ret[c] && !cons[c]) begin
                    if (cred[c] == CRED_MAX) o_cred_err <= 1'b1;
                    else cred[c] <= cred[c] + 1'b1;
                end else if (cons[c] && !i_cred_ret[c]) begin
                    cred[c] <= cred[c] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_axi.val <= 1'b0;
            o_axi.dat <= '0;
            o_axi.sop <= 1'b0;
            o_axi.eop <= 1'b0;
            o_axi.err <= 1'b0;
            o_axi.mod <= '0;
            o_axi.ctl <= '0;
        end else if (!o_axi.val || o_axi.rdy) begin
            o_axi.val <= accept;
            if (accept) begin
                o_axi.dat <= i_axi.dat;
                o_axi.sop <= i_axi.sop;
                o_axi.eop <= i_axi.eop;
                o_axi.err <= i_axi.err;
                o_axi.mod <= i_axi.mod;
                o_axi.ctl <= ctl_stamp;
            end
        end
    end
endmodule

// File: tb/tb_tree_packet_dispatch_rr.sv
// Bench for tree_packet_dispatch_rr: directed vector table, corner-case
// sequences and a random run checked against a packet-level reference model.
module tb_tree_packet_dispatch_rr;
    localparam int N  = 8;
    localparam int MC = 4;
    localparam int CB = 3;

    typedef struct {
        logic [63:0] dat;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [7:0]  ctl;
    } beat_t;

    typedef struct {
        bit         sop;
        bit         eop;
        logic [7:0] ctl;
        logic [7:0] exp_ctl;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    cred_ret;
    logic [N*CB-1:0] cred;
    logic            cred_err;

    tree_packet_dispatch_rr_if #(.DAT_BITS(64), .CTL_BITS(8), .MOD_BITS(3)) in_if ();
    tree_packet_dispatch_rr_if #(.DAT_BITS(64), .CTL_BITS(8), .MOD_BITS(3)) out_if ();

    tree_packet_dispatch_rr dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_axi      (in_if),
        .o_axi      (out_if),
        .i_cred_ret (cred_ret),
        .o_cred     (cred),
        .o_cred_err (cred_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int    m_cred [N];
    int    m_rr, m_cur;
    bit    m_in_pkt, m_err, m_full, last_acc;
    beat_t m_out;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) m_cred[c] = MC;
        m_rr = 0; m_cur = 0;
        m_in_pkt = 0; m_err = 0; m_full = 0; last_acc = 0;
        m_out = '{default: '0};
    endtask

    task automatic set_in(input bit v, input bit s, input bit e,
                          input logic [7:0] c, input logic [63:0] d);
        in_if.val = v; in_if.sop = s; in_if.eop = e;
        in_if.ctl = c; in_if.dat = d;
        in_if.err = d[0]; in_if.mod = d[3:1];
    endtask

    // Compare DUT against the model mid-cycle, then advance both one clock.
    task automatic tick();
        bit              any, exp_rdy, acc;
        int              ch, cons;
        beat_t           b;
        logic [N*CB-1:0] exp_cred;
        #3;
        any = 0;
        for (int c = 0; c < N; c++) if (m_cred[c] > 0) any = 1;
        exp_rdy = (!m_full || out_if.rdy) && (m_in_pkt || any);
        chk("in_rdy", in_if.rdy, exp_rdy);
        chk("out_val", out_if.val, m_full);
        if (m_full) begin
            chk("out_dat", out_if.dat, m_out.dat);
            chk("out_ctl", out_if.ctl, m_out.ctl);
            chk("out_flags", {out_if.sop, out_if.eop, out_if.err, out_if.mod},
                {m_out.sop, m_out.eop, m_out.err, m_out.mod});
        end
        exp_cred = '0;
        for (int c = 0; c < N; c++) exp_cred[c*CB +: CB] = CB'(m_cred[c]);
        chk("cred", cred, exp_cred);
        chk("cred_err", cred_err, m_err);

        acc  = in_if.val && exp_rdy;
        cons = -1;
        ch   = m_cur;
        b    = '{default: '0};
        if (acc) begin
            if (!m_in_pkt && in_if.sop) begin
                for (int k = N - 1; k >= 0; k--)
                    if (m_cred[(m_rr + k) % N] > 0) ch = (m_rr + k) % N;
                cons = ch; m_cur = ch; m_rr = (ch + 1) % N;
                m_in_pkt = !in_if.eop;
            end else if (m_in_pkt && in_if.eop) begin
                m_in_pkt = 0;
            end
            b.dat = in_if.dat; b.sop = in_if.sop; b.eop = in_if.eop;
            b.err = in_if.err; b.mod = in_if.mod;
            b.ctl = {3'(ch), in_if.ctl[4:0]};
        end
        if (!m_full || out_if.rdy) begin
            m_full = acc;
            if (acc) m_out = b;
        end
        for (int c = 0; c < N; c++) begin
            if (cred_ret[c] && c != cons) begin
                if (m_cred[c] == MC) m_err = 1;
                else m_cred[c]++;
            end else if (!cred_ret[c] && c == cons) begin
                m_cred[c]--;
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 8'h00, 64'h0);
        cred_ret   = '0;
        out_if.rdy = 1'b1;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_val", out_if.val, 1'b0);
        chk("rst_cred", cred, {N{3'd4}});
        chk("rst_err", cred_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl [13];

    initial begin
        bit          gen_in_pkt;
        logic [63:0] seq;

        for (int i = 0; i < 8; i++) begin
            tbl[i].sop = 1; tbl[i].eop = 1;
            tbl[i].ctl = 8'(8'hA0 + i * 3);
            tbl[i].exp_ctl = {3'(i), tbl[i].ctl[4:0]};
        end
        tbl[8]  = '{1, 0, 8'h1F, 8'h1F};
        tbl[9]  = '{0, 0, 8'h1F, 8'h1F};
        tbl[10] = '{1, 0, 8'h1F, 8'h1F};
        tbl[11] = '{0, 1, 8'h1F, 8'h1F};
        tbl[12] = '{1, 1, 8'h1F, 8'h3F};

        #1;
        do_reset();
        tick();

        for (int i = 0; i < 13; i++) begin
            set_in(1, tbl[i].sop, tbl[i].eop, tbl[i].ctl, 64'h1000 + 64'(i));
            tick();
            chk($sformatf("tbl%0d_val", i), out_if.val, 1'b1);
            chk($sformatf("tbl%0d_ctl", i), out_if.ctl, tbl[i].exp_ctl);
            if (i == 7) chk("rr_cred3", cred, {N{3'd3}});
        end
        set_in(0, 0, 0, 8'h00, 64'h0);
        tick();
        chk("multi_cred", cred, {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2});

        // Exhaust all credits, then return one on ch3.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_in(1, 1, 1, 8'h05, 64'h2000 + 64'(i));
            tick();
        end
        tick();
        chk("exh_rdy", in_if.rdy, 1'b0);
        cred_ret = 8'h08;
        tick();
        cred_ret = '0;
        tick();
        chk("exh_ch3_val", out_if.val, 1'b1);
        chk("exh_ch3", out_if.ctl[7:5], 3'd3);
        set_in(0, 0, 0, 8'h00, 64'h0);
        tick();

        // Over-return on a full channel is sticky.
        do_reset();
        cred_ret = 8'h01;
        tick();
        cred_ret = '0;
        tick();
        chk("err_set", cred_err, 1'b1);
        tick(); tick(); tick();
        chk("err_sticky", cred_err, 1'b1);

        // Consume and return on ch0 together: net zero, no error.
        do_reset();
        set_in(1, 1, 1, 8'h00, 64'h3000);
        cred_ret = 8'h01;
        tick();
        set_in(0, 0, 0, 8'h00, 64'h0);
        cred_ret = '0;
        tick();
        chk("same_cyc_cred0", cred[2:0], 3'd4);
        chk("same_cyc_err", cred_err, 1'b0);

        // Reset in the middle of a packet.
        do_reset();
        set_in(1, 1, 0, 8'h00, 64'h4000);
        tick();
        set_in(1, 0, 0, 8'h00, 64'h4001);
        tick();
        do_reset();
        set_in(1, 1, 1, 8'h00, 64'h4002);
        tick();
        chk("midrst_ch0", out_if.ctl[7:5], 3'd0);
        set_in(0, 0, 0, 8'h00, 64'h0);
        tick();

        // Random traffic with back-pressure and credit returns.
        do_reset();
        gen_in_pkt = 0;
        seq = 64'h10000;
        set_in(0, 0, 0, 8'h00, 64'h0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (last_acc) gen_in_pkt = !in_if.eop;
            if (last_acc || !in_if.val) begin
                set_in($urandom_range(0, 3) != 0, !gen_in_pkt,
                       $urandom_range(0, 2) == 0, 8'($urandom), seq);
                seq++;
            end
            out_if.rdy = 1'($urandom_range(0, 1));
            for (int c = 0; c < N; c++)
                cred_ret[c] = (m_cred[c] < MC) && ($urandom_range(0, 7) == 0);
            tick();
        end
        set_in(0, 0, 0, 8'h00, 64'h0);
        cred_ret = '0;
        out_if.rdy = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
